grab_controller: RTL

GRAB_CONTROLLER -- requirements
Module: grab_controller

---
 rtl/grab_pkg.sv | 45 ++++
 rtl/grab_controller_if.sv | 44 ++++
 rtl/obj_type_lut.sv | 17 +
 rtl/grab_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/grab_pkg.sv
// Shared types and per-object-type constants for the grab controller.
// Also used by testbenches for the obj_type_t port type.
package grab_pkg;

    localparam int unsigned MAX_SLOTS = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned COORD_W   = 11;
    localparam int unsigned RADIUS_W  = 5;
    localparam int unsigned SHIFT_W   = 2;
    localparam int unsigned VALUE_W   = 16;
    localparam int unsigned SPEED_W   = 9;

    typedef enum logic [2:0] {
        EMPTY      = 3'd0,
        SMALL_GOLD = 3'd1,
        BIG_GOLD   = 3'd2,
        ROCK       = 3'd3,
        DIAMOND    = 3'd4
    } obj_type_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        HIT,
        GRABBED,
        AWARD
    } grab_state_t;

    // Indexed by obj_type_t; codes 5..7 are unused and behave like EMPTY.
    localparam logic [RADIUS_W-1:0] RADIUS_TBL [0:7] =
        '{5'd0, 5'd8, 5'd24, 5'd16, 5'd6, 5'd0, 5'd0, 5'd0};
    localparam logic [SHIFT_W-1:0] SHIFT_TBL [0:7] =
        '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [VALUE_W-1:0] VALUE_TBL [0:7] =
        '{16'd0, 16'd50, 16'd250, 16'd20, 16'd600, 16'd0, 16'd0, 16'd0};

    // Magnitude of the 12-bit signed difference of two unsigned coordinates.
    function automatic logic [COORD_W:0] absDiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        logic [COORD_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[COORD_W] ? -d : d;
    endfunction

endpackage

// File: rtl/grab_controller_if.sv
// Hook/object/score signal bundle between the game logic (master) and grab_controller (slave).
interface grab_controller_if
    import grab_pkg::*;
#(
    parameter int NUM_OBJECTS = 8
) ();

    logic                   enable;
    logic                   startOfFrame;
    logic                   sendHook;
    logic [COORD_W-1:0]     hookX;
    logic [COORD_W-1:0]     hookY;
    logic                   hookReturnedPulse;

    logic                   objWe;
    logic [IDX_W-1:0]       objIdx;
    logic [COORD_W-1:0]     objX;
    logic [COORD_W-1:0]     objY;
    obj_type_t              objType;

    logic                   forceReturn;
    logic [SPEED_W-1:0]     extentionSpeed;
    logic                   grabbedValid;
    logic [IDX_W-1:0]       grabbedIdx;
    obj_type_t              grabbedType;
    logic                   scorePulse;
    logic [VALUE_W-1:0]     scoreValue;
    logic [NUM_OBJECTS-1:0] aliveMask;

    modport master (
        output enable, startOfFrame, sendHook, hookX, hookY, hookReturnedPulse,
        output objWe, objIdx, objX, objY, objType,
        input  forceReturn, extentionSpeed, grabbedValid, grabbedIdx, grabbedType,
        input  scorePulse, scoreValue, aliveMask
    );

    modport slave (
        input  enable, startOfFrame, sendHook, hookX, hookY, hookReturnedPulse,
        input  objWe, objIdx, objX, objY, objType,
        output forceReturn, extentionSpeed, grabbedValid, grabbedIdx, grabbedType,
        output scorePulse, scoreValue, aliveMask
    );

endinterface

// File: rtl/obj_type_lut.sv
// Combinational per-type lookup: hit radius, retraction weight shift, score value.
module obj_type_lut
    import grab_pkg::*;
(
    input  obj_type_t             objType,
    output logic [RADIUS_W-1:0]   radius,
    output logic [SHIFT_W-1:0]    weightShift,
    output logic [VALUE_W-1:0]    value
);

    always_comb begin
        radius      = RADIUS_TBL[objType];
        weightShift = SHIFT_TBL[objType];
        value       = VALUE_TBL[objType];
    end

endmodule

// File: rtl/grab_controller.sv
// Hook/object collision scanner: one slot per clock after each frame strobe, grab, award.
// Optional macro GRAB_WEIGHT_SPEED_EN slows retraction by the grabbed object's weight.
module grab_controller
    import grab_pkg::*;
#(
    parameter int         NUM_OBJECTS = 8,
    parameter logic [8:0] BASE_SPEED  = 9'd8
) (
    input logic              clk,
    input logic              reset,
    grab_controller_if.slave bus
);

    grab_state_t          state;
    grab_state_t          stateNext;
    logic                 hookOut;
    logic [IDX_W-1:0]     scanIdx;

    logic [COORD_W-1:0]   slotX    [MAX_SLOTS];
    logic [COORD_W-1:0]   slotY    [MAX_SLOTS];
    obj_type_t            slotType [MAX_SLOTS];
    logic [MAX_SLOTS-1:0] alive;

    logic [IDX_W-1:0]     grabbedIdx;
    obj_type_t            grabbedType;
    logic [VALUE_W-1:0]   scoreValue;

    obj_type_t            lutType;
    logic [RADIUS_W-1:0]  lutRadius;
    logic [SHIFT_W-1:0]   lutShift;
    logic [VALUE_W-1:0]   lutValue;

    logic [COORD_W:0]     dx;
    logic [COORD_W:0]     dy;
    logic                 scanHit;
    logic                 scanLast;
    logic                 grabNow;
    logic                 awardNow;
    logic                 objAccept;
    logic                 holding;

    // One shared LUT: scanned slot's type while scanning, grabbed type otherwise.
    assign lutType = (state == SCAN) ? slotType[scanIdx] : grabbedType;

    obj_type_lut u_lut (
        .objType     (lutType),
        .radius      (lutRadius),
        .weightShift (lutShift),
        .value       (lutValue)
    );

    assign dx       = absDiff(bus.hookX, slotX[scanIdx]);
    assign dy       = absDiff(bus.hookY, slotY[scanIdx]);
    assign scanHit  = alive[scanIdx]
                      && (dx <= (COORD_W+1)'(lutRadius))
                      && (dy <= (COORD_W+1)'(lutRadius));
    assign scanLast = (scanIdx == IDX_W'(NUM_OBJECTS - 1));

    assign grabNow   = (state == SCAN)    && (stateNext == HIT);
    assign awardNow  = (state == GRABBED) && (stateNext == AWARD);
    assign objAccept = bus.objWe && (state == IDLE) && (int'(bus.objIdx) < NUM_OBJECTS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hookOut <= 1'b0;
        end else if (!bus.enable || bus.hookReturnedPulse) begin
            hookOut <= 1'b0;
        end else if (bus.sendHook) begin
            hookOut <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (!bus.enable) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.startOfFrame && hookOut) stateNext = SCAN;
                SCAN: begin
                    if (bus.hookReturnedPulse) stateNext = IDLE;
                    else if (scanHit)          stateNext = HIT;
                    else if (scanLast)         stateNext = IDLE;
                end
                HIT:     stateNext = bus.hookReturnedPulse ? IDLE : GRABBED;
                GRABBED: if (bus.hookReturnedPulse) stateNext = AWARD;
                AWARD:   stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scanIdx <= '0;
        end else if (state == SCAN) begin
            scanIdx <= scanIdx + IDX_W'(1);
        end else begin
            scanIdx <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
                slotX[i]    <= '0;
                slotY[i]    <= '0;
                slotType[i] <= EMPTY;
            end
            alive <= '0;
        end else if (objAccept) begin
            slotX[bus.objIdx]    <= bus.objX;
            slotY[bus.objIdx]    <= bus.objY;
            slotType[bus.objIdx] <= bus.objType;
            alive[bus.objIdx]    <= (bus.objType != EMPTY);
        end else if (awardNow) begin
            alive[grabbedIdx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grabbedIdx  <= '0;
            grabbedType <= EMPTY;
            scoreValue  <= '0;
        end else begin
            if (grabNow) begin
                grabbedIdx  <= scanIdx;
                grabbedType <= slotType[scanIdx];
            end
            if (awardNow) begin
                scoreValue <= lutValue;
            end
        end
    end

    // Gated by enable so the hook is released in the same cycle the game stops.
    assign holding = bus.enable && ((state == GRABBED) || (state == AWARD));

    assign bus.forceReturn  = holding;
    assign bus.grabbedValid = holding;
    assign bus.grabbedIdx   = grabbedIdx;
    assign bus.grabbedType  = grabbedType;
    assign bus.scorePulse   = (state == AWARD);
    assign bus.scoreValue   = scoreValue;
    assign bus.aliveMask    = alive[NUM_OBJECTS-1:0];

`ifdef GRAB_WEIGHT_SPEED_EN
    logic [SPEED_W-1:0] weightedSpeed;
    assign weightedSpeed      = BASE_SPEED >> lutShift;
    assign bus.extentionSpeed = (state != GRABBED)     ? BASE_SPEED :
                                (weightedSpeed == '0)  ? SPEED_W'(1) : weightedSpeed;
`else
    logic unusedShift;
    assign unusedShift        = ^lutShift;
    assign bus.extentionSpeed = BASE_SPEED;
`endif

endmodule
